bpsk_demod_controller: RTL

//  Receive-side counterpart of the BPSK modulator controller: sequences coherent BPSK demodulation.

---
 rtl/bpsk_rx_pkg.sv | 18 +
 rtl/bpsk_demod_controller_if.sv | 26 ++
 rtl/bpsk_integrate_dump.sv | 40 ++++
 rtl/bpsk_demod_controller.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/bpsk_rx_pkg.sv
// rtl/bpsk_rx_pkg.sv - shared state encoding, width helper and sync default for the BPSK receiver
package bpsk_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        INTEG = 2'd2,
        DUMP  = 2'd3
    } rx_state_t;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

    // Accumulator is wide enough for SPB full-scale products of either sign.
    function automatic int acc_width(input int sample_w, input int spb);
        return 2 * sample_w + $clog2(spb);
    endfunction

endpackage

// File: rtl/bpsk_demod_controller_if.sv
// rtl/bpsk_demod_controller_if.sv - ADC, reference-generator and bit-sink signals of the BPSK demodulator
interface bpsk_demod_controller_if #(
    parameter int SAMPLE_W = 12
);
    logic                       adc_dav;
    logic signed [SAMPLE_W-1:0] adc_sample;
    logic                       adc_ack;
    logic signed [SAMPLE_W-1:0] sine_ref;
    logic                       sine_rdy;
    logic                       sine_rst;
    logic                       sine_clk_en;
    logic                       demod_en;
    logic                       bit_out;
    logic                       bit_valid;
    logic                       lock;

    modport master (
        input  adc_dav, adc_sample, sine_ref, sine_rdy,
        output adc_ack, sine_rst, sine_clk_en, demod_en, bit_out, bit_valid, lock
    );

    modport slave (
        output adc_dav, adc_sample, sine_ref, sine_rdy,
        input  adc_ack, sine_rst, sine_clk_en, demod_en, bit_out, bit_valid, lock
    );
endinterface

// File: rtl/bpsk_integrate_dump.sv
// rtl/bpsk_integrate_dump.sv - multiply-accumulate over one bit period, sample counter and hard slicer
module bpsk_integrate_dump
    import bpsk_rx_pkg::*;
#(
    parameter int SAMPLE_W = 12,
    parameter int SPB      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       accept,
    input  logic signed [SAMPLE_W-1:0] a,
    input  logic signed [SAMPLE_W-1:0] b,
    output logic                       last,
    output logic                       hard_bit
);
    localparam int PROD_W = 2 * SAMPLE_W;
    localparam int ACC_W  = acc_width(SAMPLE_W, SPB);
    localparam int CNT_W  = $clog2(SPB);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         cnt;

    assign prod     = PROD_W'(a) * PROD_W'(b);
    assign last     = (cnt == CNT_W'(SPB - 1));
    // A zero or positive correlation slices to 1.
    assign hard_bit = ~acc[ACC_W-1];

    // Integrate accepted products; clear has priority so a dump or stop restarts from zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= acc + ACC_W'(prod);
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/bpsk_demod_controller.sv
// rtl/bpsk_demod_controller.sv - BPSK demodulation sequencer; optional sync hunt under PREAMBLE_EN
module bpsk_demod_controller
    import bpsk_rx_pkg::*;
#(
    parameter int SAMPLE_W = 12,
    parameter int SPB      = 16
`ifdef PREAMBLE_EN
    ,
    parameter int               SYNC_W    = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(DEFAULT_SYNC_WORD)
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     PB,
    bpsk_demod_controller_if.master  bus
);
    rx_state_t state;
    logic      pb_q;
    logic      pb_rise;
    logic      dav_seen;
    logic      accept;
    logic      clr;
    logic      last;
    logic      hard_bit;

    logic      adc_ack_r;
    logic      sine_rst_r;
    logic      sine_clk_en_r;
    logic      demod_en_r;
    logic      bit_out_r;
    logic      bit_valid_r;

    assign pb_rise = PB & ~pb_q;
    // A stop request in the same cycle cancels the sample take.
    assign accept  = (state == INTEG) && bus.adc_dav && bus.sine_rdy && !dav_seen && !pb_rise;
    assign clr     = (state == DUMP) || (pb_rise && (state != IDLE));

    bpsk_integrate_dump #(
        .SAMPLE_W (SAMPLE_W),
        .SPB      (SPB)
    ) u_integrate_dump (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .accept   (accept),
        .a        (bus.adc_sample),
        .b        (bus.sine_ref),
        .last     (last),
        .hard_bit (hard_bit)
    );

`ifdef PREAMBLE_EN
    logic              lock_r;
    logic [SYNC_W-1:0] sync_sr;
    logic [SYNC_W-1:0] sync_next;

    assign sync_next = {sync_sr[SYNC_W-2:0], hard_bit};
    assign bus.lock  = lock_r;
`else
    assign bus.lock  = demod_en_r;
`endif

    // Run/stop sequencing, sample handshake and bit emission, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pb_q          <= 1'b0;
            dav_seen      <= 1'b0;
            adc_ack_r     <= 1'b0;
            sine_rst_r    <= 1'b1;
            sine_clk_en_r <= 1'b0;
            demod_en_r    <= 1'b0;
            bit_out_r     <= 1'b0;
            bit_valid_r   <= 1'b0;
`ifdef PREAMBLE_EN
            lock_r        <= 1'b0;
            sync_sr       <= '0;
`endif
        end else begin
            pb_q          <= PB;
            adc_ack_r     <= accept;
            sine_clk_en_r <= accept;
            bit_valid_r   <= 1'b0;

            if (!bus.adc_dav) begin
                dav_seen <= 1'b0;
            end else if (accept) begin
                dav_seen <= 1'b1;
            end

            if (pb_rise && (state != IDLE)) begin
                state      <= IDLE;
                sine_rst_r <= 1'b1;
                demod_en_r <= 1'b0;
                dav_seen   <= 1'b0;
`ifdef PREAMBLE_EN
                lock_r     <= 1'b0;
                sync_sr    <= '0;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                        if (pb_rise) begin
                            state      <= ARM;
                            sine_rst_r <= 1'b0;
                            demod_en_r <= 1'b1;
                        end
                    end
                    ARM: begin
                        if (bus.sine_rdy) begin
                            state <= INTEG;
                        end
                    end
                    INTEG: begin
                        if (accept && last) begin
                            state <= DUMP;
                        end
                    end
                    DUMP: begin
                        state     <= INTEG;
                        bit_out_r <= hard_bit;
`ifdef PREAMBLE_EN
                        if (lock_r) begin
                            bit_valid_r <= 1'b1;
                        end else begin
                            sync_sr <= sync_next;
                            if (sync_next == SYNC_WORD) begin
                                lock_r <= 1'b1;
                            end
                        end
`else
                        bit_valid_r <= 1'b1;
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.adc_ack     = adc_ack_r;
    assign bus.sine_rst    = sine_rst_r;
    assign bus.sine_clk_en = sine_clk_en_r;
    assign bus.demod_en    = demod_en_r;
    assign bus.bit_out     = bit_out_r;
    assign bus.bit_valid   = bit_valid_r;
endmodule
